// File: rtl/iagu_pkg.sv
// rtl/iagu_pkg.sv - shared IAGU requester indices, bank encoding and scheduler defaults
package iagu_pkg;

    // Requester slots on the IOB read scheduler
    localparam int REQ_CONV   = 0;
    localparam int REQ_SORTER = 1;
    localparam int REQ_ACTFUN = 2;
    localparam int REQ_DOT    = 3;

    localparam int IAGU_N_REQ   = 4;
    localparam int IAGU_AW      = 12;
    localparam int IAGU_TAGW    = 3;
    localparam int BANK_SEL_BIT = IAGU_AW;
    localparam int DEF_RD_LAT   = 2;

    typedef enum logic {
        BANK_IOB0 = 1'b0,
        BANK_IOB1 = 1'b1
    } bank_e;

endpackage

// File: rtl/iagu_iob_rd_sched_if.sv
// rtl/iagu_iob_rd_sched_if.sv - requester, IOB read strobe and tagged response bundle
interface iagu_iob_rd_sched_if
    import iagu_pkg::*;
#(
    parameter int N_REQ = IAGU_N_REQ,
    parameter int AW    = IAGU_AW,
    parameter int TAGW  = IAGU_TAGW
);
    logic [N_REQ-1:0]          i_req_vld;
    logic [N_REQ*(AW+1)-1:0]   i_req_addr;
    logic [N_REQ-1:0]          i_req_pad;
    logic [N_REQ-1:0]          i_req_lock;
    logic [N_REQ-1:0]          o_req_rdy;
    logic                      o_iob0_rd_en;
    logic [AW-1:0]             o_iob0_raddr;
    logic                      o_iob1_rd_en;
    logic [AW-1:0]             o_iob1_raddr;
    logic                      o_rsp0_vld;
    logic [TAGW-1:0]           o_rsp0_tag;
    logic                      o_rsp0_pad;
    logic                      o_rsp1_vld;
    logic [TAGW-1:0]           o_rsp1_tag;
    logic                      o_rsp1_pad;
    logic                      o_busy;

    modport master (
        output i_req_vld, i_req_addr, i_req_pad, i_req_lock,
        input  o_req_rdy, o_iob0_rd_en, o_iob0_raddr, o_iob1_rd_en, o_iob1_raddr,
        input  o_rsp0_vld, o_rsp0_tag, o_rsp0_pad, o_rsp1_vld, o_rsp1_tag, o_rsp1_pad,
        input  o_busy
    );

    modport slave (
        input  i_req_vld, i_req_addr, i_req_pad, i_req_lock,
        output o_req_rdy, o_iob0_rd_en, o_iob0_raddr, o_iob1_rd_en, o_iob1_raddr,
        output o_rsp0_vld, o_rsp0_tag, o_rsp0_pad, o_rsp1_vld, o_rsp1_tag, o_rsp1_pad,
        output o_busy
    );

endinterface

// File: rtl/iagu_rr_arb.sv
// rtl/iagu_rr_arb.sv - N-input round-robin arbiter with grant lock for one IOB bank
module iagu_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  lock,
    output logic [N-1:0]  gnt,
    output logic          gnt_vld,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] last_idx;
    logic          last_vld;
    logic          locked;
    logic [IW:0]   cand_w;
    logic [IW-1:0] cand;

    // Locked owner wins outright; otherwise first eligible requester at or after ptr
    always_comb begin
        locked  = last_vld && req[last_idx] && lock[last_idx] && !flush;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand_w  = '0;
        cand    = '0;
        if (locked) begin
            gnt_vld = 1'b1;
            gnt_idx = last_idx;
        end else if (!flush) begin
            for (int i = 0; i < N; i++) begin
                cand_w = {1'b0, ptr} + (IW+1)'(i);
                if (cand_w >= (IW+1)'(N)) begin
                    cand_w = cand_w - (IW+1)'(N);
                end
                cand = cand_w[IW-1:0];
                if (!gnt_vld && req[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        gnt = '0;
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Remember last owner for lock; advance pointer only on unlocked grants, keep it across flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            last_vld <= 1'b0;
            last_idx <= '0;
        end else if (flush) begin
            last_vld <= 1'b0;
        end else begin
            last_vld <= gnt_vld;
            last_idx <= gnt_idx;
            if (gnt_vld && !locked) begin
                ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iagu_iob_rd_sched.sv
// rtl/iagu_iob_rd_sched.sv - IOB read-port scheduler; IAGU_RDSCHED_PERF_EN adds stall/grant counters
module iagu_iob_rd_sched
    import iagu_pkg::*;
#(
    parameter int N_REQ  = IAGU_N_REQ,
    parameter int AW     = IAGU_AW,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int TAGW   = IAGU_TAGW
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    iagu_iob_rd_sched_if.slave       bus
`ifdef IAGU_RDSCHED_PERF_EN
    ,
    output logic [N_REQ*16-1:0]      o_perf_stall,
    output logic [31:0]              o_perf_grant
`endif
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [AW:0] addr_a   [N_REQ];
    bank_e       req_bank [N_REQ];

    // Unpack per-requester addresses and their bank selects
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            addr_a[k]   = bus.i_req_addr[k*(AW+1) +: (AW+1)];
            req_bank[k] = bank_e'(addr_a[k][AW]);
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam bank_e BANK = (b == 0) ? BANK_IOB0 : BANK_IOB1;

        logic [N_REQ-1:0] elig;
        logic [N_REQ-1:0] gnt;
        logic             gnt_vld;
        logic [IW-1:0]    gnt_idx;
        logic             iss_vld;
        logic             iss_pad;
        logic [TAGW-1:0]  iss_tag;
        logic             rd_en_q;
        logic [AW-1:0]    raddr_q;
        logic [RD_LAT-1:0] p_vld;
        logic [RD_LAT-1:0] p_pad;
        logic [TAGW-1:0]  p_tag [RD_LAT];
        logic             inflight;

        // Requesters whose current address targets this bank
        always_comb begin
            elig = '0;
            for (int k = 0; k < N_REQ; k++) begin
                elig[k] = bus.i_req_vld[k] && (req_bank[k] == BANK);
            end
        end

        iagu_rr_arb #(
            .N  (N_REQ),
            .IW (IW)
        ) u_arb (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .flush   (i_flush),
            .req     (elig),
            .lock    (bus.i_req_lock),
            .gnt     (gnt),
            .gnt_vld (gnt_vld),
            .gnt_idx (gnt_idx)
        );

        // Issue stage: register the accepted slot; pads hold the slot without strobing the IOB
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                iss_vld <= 1'b0;
                iss_pad <= 1'b0;
                iss_tag <= '0;
                rd_en_q <= 1'b0;
                raddr_q <= '0;
            end else if (i_flush) begin
                iss_vld <= 1'b0;
                iss_pad <= 1'b0;
                iss_tag <= '0;
                rd_en_q <= 1'b0;
                raddr_q <= '0;
            end else begin
                iss_vld <= gnt_vld;
                iss_pad <= gnt_vld && bus.i_req_pad[gnt_idx];
                iss_tag <= gnt_vld ? TAGW'(gnt_idx) : '0;
                rd_en_q <= gnt_vld && !bus.i_req_pad[gnt_idx];
                raddr_q <= gnt_vld ? addr_a[gnt_idx][AW-1:0] : '0;
            end
        end

        // Return pipeline: delay {vld, tag, pad} by the IOB read latency
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                p_vld <= '0;
                p_pad <= '0;
                for (int s = 0; s < RD_LAT; s++) begin
                    p_tag[s] <= '0;
                end
            end else if (i_flush) begin
                p_vld <= '0;
                p_pad <= '0;
                for (int s = 0; s < RD_LAT; s++) begin
                    p_tag[s] <= '0;
                end
            end else begin
                p_vld[0] <= iss_vld;
                p_pad[0] <= iss_pad;
                p_tag[0] <= iss_tag;
                for (int s = 1; s < RD_LAT; s++) begin
                    p_vld[s] <= p_vld[s-1];
                    p_pad[s] <= p_pad[s-1];
                    p_tag[s] <= p_tag[s-1];
                end
            end
        end

        assign inflight = iss_vld || (|p_vld);
    end

    assign bus.o_req_rdy    = g_bank[0].gnt | g_bank[1].gnt;
    assign bus.o_iob0_rd_en = g_bank[0].rd_en_q;
    assign bus.o_iob0_raddr = g_bank[0].raddr_q;
    assign bus.o_iob1_rd_en = g_bank[1].rd_en_q;
    assign bus.o_iob1_raddr = g_bank[1].raddr_q;
    assign bus.o_rsp0_vld   = g_bank[0].p_vld[RD_LAT-1];
    assign bus.o_rsp0_tag   = g_bank[0].p_tag[RD_LAT-1];
    assign bus.o_rsp0_pad   = g_bank[0].p_pad[RD_LAT-1];
    assign bus.o_rsp1_vld   = g_bank[1].p_vld[RD_LAT-1];
    assign bus.o_rsp1_tag   = g_bank[1].p_tag[RD_LAT-1];
    assign bus.o_rsp1_pad   = g_bank[1].p_pad[RD_LAT-1];
    assign bus.o_busy       = g_bank[0].inflight || g_bank[1].inflight || (|bus.i_req_vld);

`ifdef IAGU_RDSCHED_PERF_EN
    logic [15:0] stall_cnt [N_REQ];
    logic [15:0] grant_cnt [2];

    // Saturating per-requester stall counters and wrapping per-bank grant counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_REQ; k++) begin
                stall_cnt[k] <= '0;
            end
            grant_cnt[0] <= '0;
            grant_cnt[1] <= '0;
        end else if (i_flush) begin
            for (int k = 0; k < N_REQ; k++) begin
                stall_cnt[k] <= '0;
            end
            grant_cnt[0] <= '0;
            grant_cnt[1] <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (bus.i_req_vld[k] && !bus.o_req_rdy[k] && stall_cnt[k] != 16'hffff) begin
                    stall_cnt[k] <= stall_cnt[k] + 16'd1;
                end
            end
            if (g_bank[0].gnt_vld) begin
                grant_cnt[0] <= grant_cnt[0] + 16'd1;
            end
            if (g_bank[1].gnt_vld) begin
                grant_cnt[1] <= grant_cnt[1] + 16'd1;
            end
        end
    end

    // Flatten counters onto the perf ports
    always_comb begin
        o_perf_stall = '0;
        for (int k = 0; k < N_REQ; k++) begin
            o_perf_stall[k*16 +: 16] = stall_cnt[k];
        end
        o_perf_grant = {grant_cnt[1], grant_cnt[0]};
    end
`endif

endmodule

// File: tb/tb_iagu_iob_rd_sched.sv
// tb/tb_iagu_iob_rd_sched.sv - directed self-checking bench for iagu_iob_rd_sched
module tb_iagu_iob_rd_sched;
    import iagu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    iagu_iob_rd_sched_if #(.N_REQ(4), .AW(12), .TAGW(3)) bus ();

`ifdef IAGU_RDSCHED_PERF_EN
    logic [63:0] perf_stall;
    logic [31:0] perf_grant;
`endif

    iagu_iob_rd_sched #(
        .N_REQ  (4),
        .AW     (12),
        .RD_LAT (2),
        .TAGW   (3)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .bus          (bus)
`ifdef IAGU_RDSCHED_PERF_EN
        ,
        .o_perf_stall (perf_stall),
        .o_perf_grant (perf_grant)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic vld, input logic [12:0] addr,
                           input logic pad, input logic lock);
        bus.i_req_vld[k]             = vld;
        bus.i_req_addr[k*13 +: 13]   = addr;
        bus.i_req_pad[k]             = pad;
        bus.i_req_lock[k]            = lock;
    endtask

    task automatic clr_all();
        bus.i_req_vld  = '0;
        bus.i_req_addr = '0;
        bus.i_req_pad  = '0;
        bus.i_req_lock = '0;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        clr_all();

        // reset state
        at_neg();
        check("rst_rdy",   bus.o_req_rdy, 0);
        check("rst_en0",   bus.o_iob0_rd_en, 0);
        check("rst_en1",   bus.o_iob1_rd_en, 0);
        check("rst_rsp0",  bus.o_rsp0_vld, 0);
        check("rst_rsp1",  bus.o_rsp1_vld, 0);
        check("rst_busy",  bus.o_busy, 0);
        adv();
        adv();
        rst_n = 1'b1;
        adv();

        // T1: requester 0 streams 0x010..0x012 on bank 0
        for (int i = 0; i < 7; i++) begin
            clr_all();
            if (i < 3) set_req(REQ_CONV, 1'b1, 13'h010 + 13'(i), 1'b0, 1'b0);
            at_neg();
            check("t1_rdy", bus.o_req_rdy, (i < 3) ? 32'h1 : 32'h0);
            check("t1_en0", bus.o_iob0_rd_en, (i >= 1 && i <= 3));
            if (i >= 1 && i <= 3) check("t1_raddr0", bus.o_iob0_raddr, 32'h010 + i - 1);
            check("t1_rsp0", bus.o_rsp0_vld, (i >= 3 && i <= 5));
            if (i >= 3 && i <= 5) check("t1_tag0", bus.o_rsp0_tag, 0);
            adv();
        end

        // T2: all four requesters on bank 1, round-robin 0,1,2,3,0
        for (int i = 0; i < 9; i++) begin
            clr_all();
            if (i < 5) begin
                for (int k = 0; k < 4; k++) set_req(k, 1'b1, 13'h1040 + 13'(k), 1'b0, 1'b0);
            end
            at_neg();
            check("t2_rdy", bus.o_req_rdy, (i < 5) ? 32'(1 << (i % 4)) : 32'h0);
            check("t2_en0", bus.o_iob0_rd_en, 0);
            check("t2_en1", bus.o_iob1_rd_en, (i >= 1 && i <= 5));
            if (i >= 1 && i <= 5) check("t2_raddr1", bus.o_iob1_raddr, 32'h040 + ((i - 1) % 4));
            check("t2_rsp1", bus.o_rsp1_vld, (i >= 3 && i <= 7));
            if (i >= 3 && i <= 7) check("t2_tag1", bus.o_rsp1_tag, (i - 3) % 4);
            adv();
        end

        // T3: requester 2 locks bank 0 for four beats, requester 1 waits then wins
        for (int i = 0; i < 9; i++) begin
            clr_all();
            if (i <= 3) set_req(REQ_ACTFUN, 1'b1, 13'h060 + 13'(i), 1'b0, 1'b1);
            if (i == 4) set_req(REQ_ACTFUN, 1'b1, 13'h064, 1'b0, 1'b0);
            if (i >= 1 && i <= 4) set_req(REQ_SORTER, 1'b1, 13'h070, 1'b0, 1'b0);
            at_neg();
            check("t3_rdy", bus.o_req_rdy, (i <= 3) ? 32'h4 : ((i == 4) ? 32'h2 : 32'h0));
            check("t3_rsp0", bus.o_rsp0_vld, (i >= 3 && i <= 7));
            if (i >= 3 && i <= 7) check("t3_tag0", bus.o_rsp0_tag, (i == 7) ? 1 : 2);
            adv();
        end

        // T4: requester 0 on bank 0 and requester 3 on bank 1 in the same cycle
        for (int i = 0; i < 5; i++) begin
            clr_all();
            if (i == 0) begin
                set_req(REQ_CONV, 1'b1, 13'h0003, 1'b0, 1'b0);
                set_req(REQ_DOT,  1'b1, 13'h1005, 1'b0, 1'b0);
            end
            at_neg();
            check("t4_rdy", bus.o_req_rdy, (i == 0) ? 32'h9 : 32'h0);
            check("t4_en0", bus.o_iob0_rd_en, (i == 1));
            check("t4_en1", bus.o_iob1_rd_en, (i == 1));
            if (i == 1) begin
                check("t4_raddr0", bus.o_iob0_raddr, 32'h003);
                check("t4_raddr1", bus.o_iob1_raddr, 32'h005);
            end
            check("t4_rsp0", bus.o_rsp0_vld, (i == 3));
            check("t4_rsp1", bus.o_rsp1_vld, (i == 3));
            if (i == 3) begin
                check("t4_tag0", bus.o_rsp0_tag, 0);
                check("t4_tag1", bus.o_rsp1_tag, 3);
            end
            adv();
        end

        // T5: pad slot from requester 1
        for (int i = 0; i < 5; i++) begin
            clr_all();
            if (i == 0) set_req(REQ_SORTER, 1'b1, 13'h020, 1'b1, 1'b0);
            at_neg();
            check("t5_rdy", bus.o_req_rdy, (i == 0) ? 32'h2 : 32'h0);
            check("t5_en0", bus.o_iob0_rd_en, 0);
            if (i == 1) check("t5_busy", bus.o_busy, 1);
            check("t5_rsp0", bus.o_rsp0_vld, (i == 3));
            check("t5_pad0", bus.o_rsp0_pad, (i == 3));
            if (i == 3) check("t5_tag0", bus.o_rsp0_tag, 1);
            adv();
        end

        // T6: flush blocks grants and drops the read already issued
        for (int i = 0; i < 5; i++) begin
            clr_all();
            flush = (i == 1);
            if (i == 0) set_req(REQ_ACTFUN, 1'b1, 13'h050, 1'b0, 1'b0);
            if (i == 1) set_req(REQ_SORTER, 1'b1, 13'h051, 1'b0, 1'b0);
            at_neg();
            check("t6_rdy", bus.o_req_rdy, (i == 0) ? 32'h4 : 32'h0);
            check("t6_en0", bus.o_iob0_rd_en, (i == 1));
            check("t6_rsp0", bus.o_rsp0_vld, 0);
            if (i == 2) check("t6_busy", bus.o_busy, 0);
            adv();
        end
        flush = 1'b0;

        // T7: reset with two responses in flight, then five clean reads
        for (int i = 0; i < 2; i++) begin
            clr_all();
            set_req(REQ_CONV, 1'b1, 13'h030 + 13'(i), 1'b0, 1'b0);
            at_neg();
            check("t7_rdy", bus.o_req_rdy, 1);
            adv();
        end
        clr_all();
        rst_n = 1'b0;
        #1;
        check("t7_rst_en0",   bus.o_iob0_rd_en, 0);
        check("t7_rst_raddr", bus.o_iob0_raddr, 0);
        check("t7_rst_rsp0",  bus.o_rsp0_vld, 0);
        check("t7_rst_busy",  bus.o_busy, 0);
        adv();
        adv();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            check("t7_idle_rsp0", bus.o_rsp0_vld, 0);
            check("t7_idle_busy", bus.o_busy, 0);
            adv();
        end
        for (int i = 0; i < 9; i++) begin
            clr_all();
            if (i < 5) set_req(REQ_CONV, 1'b1, 13'h040 + 13'(i), 1'b0, 1'b0);
            at_neg();
            check("t7_rdy2", bus.o_req_rdy, (i < 5) ? 32'h1 : 32'h0);
            check("t7_en0", bus.o_iob0_rd_en, (i >= 1 && i <= 5));
            if (i >= 1 && i <= 5) check("t7_raddr0", bus.o_iob0_raddr, 32'h040 + i - 1);
            check("t7_rsp0", bus.o_rsp0_vld, (i >= 3 && i <= 7));
            if (i >= 3 && i <= 7) check("t7_tag0", bus.o_rsp0_tag, 0);
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iagu_iob_rd_sched.md
Name: iagu_iob_rd_sched

Overview:
- Scheduler for the two input-buffer (IOB) read ports shared by the IAGU address generators: conv/pool/FC, sorter, actfun and dot.
- Each requester presents a stream of 13-bit addresses. Bit 12 selects the bank: 0 = IOB0 port, 1 = IOB1 port.
- Per-bank round-robin arbitration with burst lock.
- Issues registered read strobes and returns a tagged, latency-aligned response valid so the PE side knows which requester owns each returning word.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- AW, 12, bank-local address width
- RD_LAT, 2, IOB read latency in cycles from o_iobN_rd_en to data valid (1..4)
- TAGW, 3, width of requester index tag; must satisfy 2**TAGW >= N_REQ

Ports:
- i_clk, in, 1, clock
- i_rst_n, in, 1, asynchronous active-low reset
- i_flush, in, 1, synchronous clear of arbitration and return pipeline
- i_req_vld, in, N_REQ, per-requester address valid
- i_req_addr, in, N_REQ*(AW+1), per-requester address; bit AW is bank select
- i_req_pad, in, N_REQ, address is padding; no IOB access
- i_req_lock, in, N_REQ, hold grant on the current bank while asserted
- o_req_rdy, out, N_REQ, request accepted this cycle
- o_iob0_rd_en, out, 1, IOB0 read strobe
- o_iob0_raddr, out, AW, IOB0 read address
- o_iob1_rd_en, out, 1, IOB1 read strobe
- o_iob1_raddr, out, AW, IOB1 read address
- o_rsp0_vld, out, 1, IOB0 data valid, or pad slot on bank 0
- o_rsp0_tag, out, TAGW, requester index for rsp0
- o_rsp0_pad, out, 1, rsp0 slot is padding; consumer substitutes zero
- o_rsp1_vld, out, 1, same as rsp0, for bank 1
- o_rsp1_tag, out, TAGW, same as rsp0, for bank 1
- o_rsp1_pad, out, 1, same as rsp0, for bank 1
- o_busy, out, 1, any response in flight or any i_req_vld high

Behaviour:
- Reset: async, active-low. All outputs 0, round-robin pointers 0, lock owners cleared, return pipelines cleared. Reset mid-transfer discards in-flight responses; no response appears after reset release until new requests are accepted.
- Per bank b, eligible requesters are k with i_req_vld[k] and i_req_addr[k][AW] == b.
- Round-robin per bank: search starts at ptr_b. After a grant to k, ptr_b becomes (k+1) mod N_REQ.
- Lock: if the requester granted on bank b last cycle has i_req_lock high and is still eligible on b, it is granted again. The pointer does not advance while the lock is held. The lock ends when lock drops or the requester stops being eligible.
- Grant is combinational. o_req_rdy[k] is high in the same cycle as the grant; a transfer occurs on vld & rdy. At most one grant per bank per cycle; a requester can win at most one bank per cycle, since it has one address.
- Pad requests arbitrate exactly like reads: they occupy the bank slot, keeping per-bank order and timing. They do not assert oN_rd_en.
- Issue stage (registered, 1 cycle after acceptance): oN_rd_en = granted & ~pad; oN_raddr = granted addr[AW-1:0], else 0.
- Return pipeline per bank: depth RD_LAT shift register of {vld, tag, pad}. o_rspN_* appears exactly RD_LAT cycles after oN_rd_en, i.e. RD_LAT+1 cycles after acceptance.
- Per-requester, per-bank order is preserved. There is no cross-bank ordering guarantee.
- i_flush: no grants that cycle (o_req_rdy = 0). Next cycle: issue and return pipelines and lock state cleared. Pointers are kept.
- Simultaneous flush and reset: reset dominates.
- Starvation bound: a non-locked eligible requester is granted within N_REQ-1 grants on its bank, plus the duration of any active lock.

Optional Feature:
- Macro IAGU_RDSCHED_PERF_EN.
- Defined: adds per-requester 16-bit saturating stall counters, incremented when vld & ~rdy & ~i_flush, and a 16-bit per-bank grant counter. All counters are cleared by reset or i_flush. Adds output ports o_perf_stall (N_REQ*16) and o_perf_grant (2*16).
- Undefined: no counters and no extra ports; functionally identical otherwise.

Decomposition:
- Shared package iagu_pkg: requester index constants REQ_CONV=0, REQ_SORTER=1, REQ_ACTFUN=2, REQ_DOT=3; bank select bit position; default RD_LAT.
- One natural sub-module, iagu_rr_arb: N-input round-robin arbiter with lock input, one-hot grant and pointer. Instantiated once per bank.

Test Plan:
- Single requester 0 sends addrs 0x010, 0x011, 0x012 on bank 0 -> o_iob0_rd_en pulses at cycles t+1..t+3 with those addresses; rsp0_vld at t+3..t+5 with tag 0 (RD_LAT=2).
- Requesters 0..3 all continuously valid on bank 1 -> grant order 0,1,2,3,0; o_iob0_rd_en never asserted.
- Requester 2 holds lock for 4 beats while requester 1 is valid, both on bank 0 -> four consecutive grants to 2, then 1 granted on the next cycle.
- Requester 0 on bank 0 and requester 3 on bank 1 (addr 0x1005) in the same cycle -> both accepted; o_iob1_raddr = 0x005; both responses return in the same cycle.
- Pad request from requester 1 at addr 0x020 -> no rd_en, o_rsp0_vld=1 and o_rsp0_pad=1 with tag 1 after 3 cycles.
- Reset asserted with 2 responses in flight -> all outputs 0 immediately; no response after release; 5 requests afterwards complete normally.
